// File: rtl/graph_edge_packer_pkg.sv
// graph_pkg: shared widths, packed edge layout and FSM states for the
// shortest-path solver's graph input path (used by packer and solver).
package graph_pkg;

  localparam int NODE_W    = 4;
  localparam int WEIGHT_W  = 4;
  localparam int EDGE_W    = 2 * NODE_W + WEIGHT_W;
  localparam int SLOTS     = 256;
  localparam int MAX_EDGES = 255;
  localparam int COUNT_W   = 8;

  // Bit order matters: the solver reads slot bits as {weight, child, parent}.
  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic [NODE_W-1:0]   child;
    logic [NODE_W-1:0]   parent;
  } edge_t;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [NODE_W-1:0] node_max(input logic [NODE_W-1:0] a,
                                                 input logic [NODE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/graph_edge_packer_if.sv
// Edge input stream plus packed-frame output handshake between the
// upstream producer/solver (master) and the edge packer (slave).
interface graph_edge_packer_if;
  import graph_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NODE_W-1:0]    in_parent;
  logic [NODE_W-1:0]    in_child;
  logic [WEIGHT_W-1:0]  in_weight;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [NODE_W-1:0]    out_n;
  logic [COUNT_W-1:0]   out_e;
  logic [SLOTS*EDGE_W-1:0] out_data;
  logic                 err_node;
  logic                 err_overflow;

  modport master (
    output in_valid, in_parent, in_child, in_weight, in_last, out_ready,
    input  in_ready, out_valid, out_n, out_e, out_data, err_node, err_overflow
  );

  modport slave (
    input  in_valid, in_parent, in_child, in_weight, in_last, out_ready,
    output in_ready, out_valid, out_n, out_e, out_data, err_node, err_overflow
  );

endinterface

// File: rtl/graph_edge_check.sv
// Combinational classification of one incoming edge beat: is it storable,
// does it name node 0, is the edge list already full. With
// SELF_LOOP_FILTER_EN defined, parent==child edges are also flagged.
module graph_edge_check
  import graph_pkg::*;
(
  input  logic [NODE_W-1:0]  i_parent,
  input  logic [NODE_W-1:0]  i_child,
  input  logic [COUNT_W-1:0] i_count,
  output logic               o_store,
  output logic               o_bad_node,
  output logic               o_overflow
`ifdef SELF_LOOP_FILTER_EN
  ,
  output logic               o_self_loop
`endif
);

  // Classify the beat; node 0 and a full list are independent reasons to drop.
  always_comb begin
    o_bad_node = (i_parent == '0) || (i_child == '0);
    o_overflow = (i_count == COUNT_W'(MAX_EDGES));
`ifdef SELF_LOOP_FILTER_EN
    o_self_loop = !o_bad_node && (i_parent == i_child);
    o_store     = !o_bad_node && !o_overflow && !o_self_loop;
`else
    o_store     = !o_bad_node && !o_overflow;
`endif
  end

endmodule

// File: rtl/graph_edge_packer.sv
// graph_edge_packer: collects edges one beat at a time and packs them into
// the solver's flat 256 x 12-bit edge list, then holds the frame until the
// solver takes it. Optional macro SELF_LOOP_FILTER_EN drops parent==child
// edges silently instead of storing them.
module graph_edge_packer
  import graph_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  graph_edge_packer_if.slave bus
);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_clear;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_store;
  logic                w_bad_node;
  logic                w_overflow;
  edge_t               w_edge;

  logic [COUNT_W-1:0]  r_count;
  logic [NODE_W-1:0]   r_nmax;
  logic                r_err_node;
  logic                r_err_overflow;
  logic [EDGE_W-1:0]   r_slot [SLOTS];

`ifdef SELF_LOOP_FILTER_EN
  logic                w_self_loop;
`endif

  graph_edge_check u_check (
    .i_parent   (bus.in_parent),
    .i_child    (bus.in_child),
    .i_count    (r_count),
    .o_store    (w_store),
    .o_bad_node (w_bad_node),
    .o_overflow (w_overflow)
`ifdef SELF_LOOP_FILTER_EN
    ,
    .o_self_loop(w_self_loop)
`endif
  );

  assign w_edge   = '{weight: bus.in_weight, child: bus.in_child, parent: bus.in_parent};
  assign w_accept = bus.in_valid && w_in_ready;
`ifdef SELF_LOOP_FILTER_EN
  assign w_wr_en  = w_accept && w_store && !w_self_loop;
`else
  assign w_wr_en  = w_accept && w_store;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= COLLECT;
    else        r_state <= w_state_next;
  end

  // Next state and handshake outputs; the handoff edge also clears the frame.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      COLLECT: begin
        w_in_ready = 1'b1;
        // in_last ends the frame even when the final beat itself is dropped.
        if (bus.in_valid && bus.in_last) w_state_next = PRESENT;
      end
      PRESENT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = COLLECT;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  // Edge count, highest node index and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset || w_clear) begin
      r_count        <= '0;
      r_nmax         <= '0;
      r_err_node     <= 1'b0;
      r_err_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_wr_en) begin
        r_count <= r_count + COUNT_W'(1);
        r_nmax  <= node_max(node_max(r_nmax, bus.in_parent), bus.in_child);
      end
      if (w_bad_node) r_err_node     <= 1'b1;
      if (w_overflow) r_err_overflow <= 1'b1;
    end
  end

  // Slot storage; every slot is cleared at once so unused slots read as zero.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SLOTS; k++) begin
      if (!reset || w_clear)
        r_slot[k] <= '0;
      else if (w_wr_en && (r_count == k[COUNT_W-1:0]))
        r_slot[k] <= w_edge;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_pack
      assign bus.out_data[gi*EDGE_W +: EDGE_W] = r_slot[gi];
    end
  endgenerate

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_n        = r_nmax;
  assign bus.out_e        = r_count;
  assign bus.err_node     = r_err_node;
  assign bus.err_overflow = r_err_overflow;

endmodule

// File: tb/tb_graph_edge_packer.sv
// Self-checking bench for graph_edge_packer: directed frames from the test
// plan followed by random frames, checked against a queue-based edge model.
module tb_graph_edge_packer;
  import graph_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  graph_edge_packer_if ifc ();

  graph_edge_packer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: the list of stored edges, highest node, sticky flags.
  edge_t       m_q[$];
  logic [3:0]  m_nmax;
  logic        m_errn;
  logic        m_erro;

  function automatic void model_clear();
    m_q.delete();
    m_nmax = '0;
    m_errn = 1'b0;
    m_erro = 1'b0;
  endfunction

  function automatic void model_beat(logic [3:0] p, logic [3:0] c, logic [3:0] w);
    bit sl = 1'b0;
`ifdef SELF_LOOP_FILTER_EN
    sl = (p == c);
`endif
    if (p == 4'd0 || c == 4'd0) m_errn = 1'b1;
    if (m_q.size() == MAX_EDGES) m_erro = 1'b1;
    if (p != 4'd0 && c != 4'd0 && m_q.size() < MAX_EDGES && !sl) begin
      m_q.push_back('{weight: w, child: c, parent: p});
      if (p > m_nmax) m_nmax = p;
      if (c > m_nmax) m_nmax = c;
    end
  endfunction

  function automatic logic [SLOTS*EDGE_W-1:0] model_data();
    logic [SLOTS*EDGE_W-1:0] d = '0;
    foreach (m_q[i]) d[i*EDGE_W +: EDGE_W] = m_q[i];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag);
    logic [SLOTS*EDGE_W-1:0] exp;
    int k;
    exp = model_data();
    total++;
    assert (ifc.out_data === exp)
    else begin
      bad++;
      k = 0;
      while (k < SLOTS - 1 && ifc.out_data[k*EDGE_W +: EDGE_W] === exp[k*EDGE_W +: EDGE_W]) k++;
      $error("FAIL %s slot=%0d observed=%03h expected=%03h", tag, k,
             ifc.out_data[k*EDGE_W +: EDGE_W], exp[k*EDGE_W +: EDGE_W]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and wait for its handshake; called at #1 after an edge.
  task automatic send(input logic [3:0] p, input logic [3:0] c, input logic [3:0] w,
                      input logic l);
    int k = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_parent = p;
    ifc.in_child  = c;
    ifc.in_weight = w;
    ifc.in_last   = l;
    while (ifc.in_ready !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    assert (k < 50)
    else begin
      bad++;
      $error("FAIL send_timeout observed=%0d expected=<50", k);
    end
    if (l) chk("pre_last_out_valid", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    model_beat(p, c, w);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic check_present(input string tag);
    chk({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({tag, ".in_ready"}, 32'(ifc.in_ready), 32'd0);
    chk({tag, ".out_e"}, 32'(ifc.out_e), 32'(m_q.size()));
    chk({tag, ".out_n"}, 32'(ifc.out_n), 32'(m_nmax));
    chk({tag, ".err_node"}, 32'(ifc.err_node), 32'(m_errn));
    chk({tag, ".err_overflow"}, 32'(ifc.err_overflow), 32'(m_erro));
    chk_data({tag, ".out_data"});
  endtask

  // Hold a few cycles, then let the solver take the frame and check the handoff.
  task automatic release_frame(input string tag);
    int hold;
    hold = int'($urandom_range(0, 2));
    repeat (hold) begin
      idle(1);
      chk({tag, ".hold_valid"}, 32'(ifc.out_valid), 32'd1);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    ifc.out_ready = 1'b0;
    chk({tag, ".rel_out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, ".rel_in_ready"}, 32'(ifc.in_ready), 32'd1);
    chk({tag, ".rel_out_e"}, 32'(ifc.out_e), 32'd0);
    chk({tag, ".rel_out_n"}, 32'(ifc.out_n), 32'd0);
    chk({tag, ".rel_err_node"}, 32'(ifc.err_node), 32'd0);
    chk({tag, ".rel_err_overflow"}, 32'(ifc.err_overflow), 32'd0);
    chk_data({tag, ".rel_out_data"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] p, c, w;
    int len;
    ifc.in_valid  = 1'b0;
    ifc.in_parent = '0;
    ifc.in_child  = '0;
    ifc.in_weight = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    chk("rst.in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst.out_e", 32'(ifc.out_e), 32'd0);
    chk("rst.out_n", 32'(ifc.out_n), 32'd0);
    chk("rst.err_node", 32'(ifc.err_node), 32'd0);
    chk("rst.err_overflow", 32'(ifc.err_overflow), 32'd0);
    chk_data("rst.out_data");

    // Two-edge frame.
    send(4'd1, 4'd2, 4'd5, 1'b0);
    send(4'd2, 4'd3, 4'd7, 1'b1);
    check_present("t1");
    chk("t1.const_e", 32'(ifc.out_e), 32'd2);
    chk("t1.const_n", 32'(ifc.out_n), 32'd3);
    chk("t1.slot0", 32'(ifc.out_data[11:0]), 32'h521);
    chk("t1.slot1", 32'(ifc.out_data[23:12]), 32'h732);
    release_frame("t1");

    // Node 0 beat alone: empty frame with err_node.
    send(4'd0, 4'd4, 4'd1, 1'b1);
    check_present("t2");
    chk("t2.const_err_node", 32'(ifc.err_node), 32'd1);
    chk("t2.const_e", 32'(ifc.out_e), 32'd0);
    release_frame("t2");

    // Overflow: 256 beats, the last one dropped.
    for (int i = 0; i < 256; i++) send(4'd1, 4'd2, 4'd1, (i == 255));
    check_present("t3");
    chk("t3.const_e", 32'(ifc.out_e), 32'd255);
    chk("t3.const_ovf", 32'(ifc.err_overflow), 32'd1);
    chk("t3.slot254", 32'(ifc.out_data[254*EDGE_W +: EDGE_W]), 32'h121);
    chk("t3.slot255", 32'(ifc.out_data[255*EDGE_W +: EDGE_W]), 32'h0);
    // Solver stalls while upstream keeps pushing.
    ifc.in_valid  = 1'b1;
    ifc.in_parent = 4'd7;
    ifc.in_child  = 4'd8;
    ifc.in_weight = 4'd9;
    ifc.in_last   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("t3.stall_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("t3.stall_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("t3.stall_out_e", 32'(ifc.out_e), 32'd255);
    end
    chk_data("t3.stall_out_data");
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    release_frame("t3");

    // Reset mid-frame discards partial contents.
    send(4'd4, 4'd5, 4'd3, 1'b0);
    send(4'd6, 4'd7, 4'd1, 1'b0);
    send(4'd2, 4'd9, 4'd8, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b1;
    send(4'd5, 4'd6, 4'd2, 1'b1);
    check_present("t4");
    chk("t4.const_e", 32'(ifc.out_e), 32'd1);
    chk("t4.const_n", 32'(ifc.out_n), 32'd6);
    chk("t4.slot0", 32'(ifc.out_data[11:0]), 32'h265);
    release_frame("t4");

    // Self-loop handling.
    send(4'd3, 4'd3, 4'd4, 1'b0);
    send(4'd1, 4'd2, 4'd1, 1'b1);
    check_present("t5");
`ifdef SELF_LOOP_FILTER_EN
    chk("t5.const_e", 32'(ifc.out_e), 32'd1);
    chk("t5.slot0", 32'(ifc.out_data[11:0]), 32'h121);
    chk("t5.const_n", 32'(ifc.out_n), 32'd2);
`else
    chk("t5.const_e", 32'(ifc.out_e), 32'd2);
    chk("t5.slot0", 32'(ifc.out_data[11:0]), 32'h433);
    chk("t5.slot1", 32'(ifc.out_data[23:12]), 32'h121);
    chk("t5.const_n", 32'(ifc.out_n), 32'd3);
`endif
    release_frame("t5");

    // Random frames with gaps and occasional node-0 beats.
    for (int f = 0; f < 30; f++) begin
      len = int'($urandom_range(1, 24));
      for (int b = 0; b < len; b++) begin
        idle(int'($urandom_range(0, 2)));
        p = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        c = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        w = 4'($urandom_range(0, 15));
        send(p, c, w, (b == len - 1));
      end
      check_present("rnd");
      release_frame("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
